l2_cacheline_adapter: RTL and testbench

L2_CACHELINE_ADAPTER -- requirements
Module: l2_cacheline_adapter

---
 rtl/l2_cacheline_adapter.sv | 116 +++++++++++
 tb/tb_l2_cacheline_adapter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cacheline_adapter.sv
// L2 cache line adapter: splits/assembles s_line-bit cache lines
// into s_burst-bit memory beats using a simple request/beat handshake.
module l2_cacheline_adapter #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [s_line-1:0] line_i,
    output logic [s_line-1:0] line_o,
    input  logic [31:0]       address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [31:0]       address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i
);

    localparam int beats = s_line / s_burst;
    localparam int cw    = (beats > 1) ? $clog2(beats) : 1;
    localparam logic [cw-1:0] last_c = cw'(beats - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [cw-1:0]       cnt_q, cnt_d;
    logic [31:0]         addr_q, addr_d;
    logic [s_line-1:0]   wline_q, wline_d;
    logic [s_line-1:0]   rbuf_q, rbuf_d;
    logic [s_line-1:0]   line_q, line_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rbuf_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rbuf_q  <= rbuf_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rbuf_d  = rbuf_q;
        line_d  = line_q;
        unique case (state_q)
            IDLE: begin
                if (write_i) begin
                    addr_d  = address_i;
                    wline_d = line_i;
                    cnt_d   = '0;
                    state_d = WRITE;
                end else if (read_i) begin
                    addr_d  = address_i;
                    cnt_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (resp_i) begin
                    rbuf_d[int'(cnt_q)*s_burst +: s_burst] = burst_i;
                    cnt_d = cnt_q + 1'b1;
                    // line_o only updates once the whole line has arrived
                    if (cnt_q == last_c) begin
                        line_d  = rbuf_d;
                        state_d = DONE;
                    end
                end
            end
            WRITE: begin
                if (resp_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == last_c) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign read_o    = (state_q == READ);
    assign write_o   = (state_q == WRITE);
    assign resp_o    = (state_q == DONE);
    assign line_o    = line_q;
    assign address_o = addr_q & 32'hFFFF_FFE0;
    assign burst_o   = (state_q == WRITE)
                     ? wline_q[int'(cnt_q)*s_burst +: s_burst]
                     : '0;

endmodule

// File: tb/tb_l2_cacheline_adapter.sv
// Scoreboard bench for l2_cacheline_adapter: read, write, arbitration,
// mid-transfer reset and spurious-handshake scenarios.
module tb_l2_cacheline_adapter;

    localparam int LW = 256;
    localparam int BW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [LW-1:0] line_i;
    logic [LW-1:0] line_o;
    logic [31:0]   address_i;
    logic          read_i;
    logic          write_i;
    logic          resp_o;
    logic [BW-1:0] burst_i;
    logic [BW-1:0] burst_o;
    logic [31:0]   address_o;
    logic          read_o;
    logic          write_o;
    logic          resp_i;

    int n_cmp = 0;
    int n_err = 0;

    logic [BW-1:0] exp_beats[$];
    logic [LW-1:0] exp_lines[$];
    logic [LW-1:0] last_line;

    l2_cacheline_adapter #(.s_line(LW), .s_burst(BW)) dut (
        .clk       (clk),
        .reset     (reset),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        read_i = 0; write_i = 0; resp_i = 0;
        line_i = '0; address_i = '0; burst_i = '0;
        #2;
        reset = 1'b0;
        #1;
        last_line = '0;
        n_cmp++;
        if ({read_o, write_o, resp_o} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctrl got %b want 000", {read_o, write_o, resp_o});
        end
        n_cmp++;
        if (burst_o !== '0) begin
            n_err++;
            $display("FAIL reset_burst got %h want 0", burst_o);
        end
        n_cmp++;
        if (address_o !== 32'h0) begin
            n_err++;
            $display("FAIL reset_addr got %h want 0", address_o);
        end
        n_cmp++;
        if (line_o !== last_line) begin
            n_err++;
            $display("FAIL reset_line got %h want 0", line_o);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_read();
        logic [LW-1:0] l;
        address_i = 32'h1234_5678;
        read_i = 1'b1;
        l = '0;
        for (int i = 0; i < 4; i++) begin
            l[i*BW +: BW] = {16{i[3:0]}};
        end
        exp_lines.push_back(l);
        tick();
        read_i = 1'b0;
        n_cmp++;
        if (read_o !== 1'b1 || write_o !== 1'b0) begin
            n_err++;
            $display("FAIL read_req got r=%b w=%b want r=1 w=0", read_o, write_o);
        end
        n_cmp++;
        if (address_o !== 32'h1234_5660) begin
            n_err++;
            $display("FAIL read_addr got %h want 12345660", address_o);
        end
        for (int i = 0; i < 4; i++) begin
            resp_i = 1'b0;
            burst_i = '0;
            tick();
            n_cmp++;
            if (read_o !== 1'b1 || resp_o !== 1'b0 || line_o !== last_line) begin
                n_err++;
                $display("FAIL read_wait%0d got r=%b resp=%b line=%h want r=1 resp=0 line=%h",
                         i, read_o, resp_o, line_o, last_line);
            end
            resp_i = 1'b1;
            burst_i = {16{i[3:0]}};
            tick();
        end
        resp_i = 1'b0;
        n_cmp++;
        if (resp_o !== 1'b1 || read_o !== 1'b0) begin
            n_err++;
            $display("FAIL read_resp got resp=%b r=%b want resp=1 r=0", resp_o, read_o);
        end
        l = exp_lines.pop_front();
        last_line = l;
        n_cmp++;
        if (line_o !== l) begin
            n_err++;
            $display("FAIL read_line got %h want %h", line_o, l);
        end
        tick();
        n_cmp++;
        if (resp_o !== 1'b0) begin
            n_err++;
            $display("FAIL read_resp_pulse got %b want 0", resp_o);
        end
    endtask

    task automatic test_write();
        logic [BW-1:0] e;
        line_i = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        exp_beats.push_back({16{4'hA}});
        exp_beats.push_back({16{4'hB}});
        exp_beats.push_back({16{4'hC}});
        exp_beats.push_back({16{4'hD}});
        address_i = 32'h0000_ABFF;
        write_i = 1'b1;
        tick();
        write_i = 1'b0;
        line_i = '1;
        for (int i = 0; i < 4; i++) begin
            resp_i = 1'b0;
            tick();
            e = exp_beats.pop_front();
            n_cmp++;
            if (write_o !== 1'b1 || read_o !== 1'b0 || burst_o !== e) begin
                n_err++;
                $display("FAIL write_beat%0d got w=%b r=%b burst=%h want w=1 r=0 burst=%h",
                         i, write_o, read_o, burst_o, e);
            end
            resp_i = 1'b1;
            tick();
        end
        resp_i = 1'b0;
        n_cmp++;
        if (resp_o !== 1'b1 || write_o !== 1'b0 || burst_o !== '0) begin
            n_err++;
            $display("FAIL write_resp got resp=%b w=%b burst=%h want resp=1 w=0 burst=0",
                     resp_o, write_o, burst_o);
        end
        n_cmp++;
        if (line_o !== last_line) begin
            n_err++;
            $display("FAIL write_line_o got %h want %h", line_o, last_line);
        end
        n_cmp++;
        if (address_o !== 32'h0000_ABE0) begin
            n_err++;
            $display("FAIL write_addr got %h want 0000abe0", address_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] e;
        logic [LW-1:0] l;
        logic [BW-1:0] b;
        line_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            exp_beats.push_back(line_i[i*BW +: BW]);
        end
        address_i = 32'h8000_0040;
        read_i = 1'b1;
        write_i = 1'b1;
        tick();
        write_i = 1'b0;
        resp_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = exp_beats.pop_front();
            n_cmp++;
            if (write_o !== 1'b1 || read_o !== 1'b0 || burst_o !== e) begin
                n_err++;
                $display("FAIL arb_beat%0d got w=%b r=%b burst=%h want w=1 r=0 burst=%h",
                         i, write_o, read_o, burst_o, e);
            end
            tick();
        end
        resp_i = 1'b0;
        n_cmp++;
        if (resp_o !== 1'b1 || read_o !== 1'b0) begin
            n_err++;
            $display("FAIL arb_resp got resp=%b r=%b want resp=1 r=0", resp_o, read_o);
        end
        tick();
        n_cmp++;
        if (read_o !== 1'b0 || write_o !== 1'b0) begin
            n_err++;
            $display("FAIL arb_idle got r=%b w=%b want 0 0", read_o, write_o);
        end
        tick();
        read_i = 1'b0;
        l = '0;
        n_cmp++;
        if (read_o !== 1'b1) begin
            n_err++;
            $display("FAIL held_read_req got %b want 1", read_o);
        end
        resp_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b = {$urandom, $urandom};
            l[i*BW +: BW] = b;
            burst_i = b;
            tick();
        end
        exp_lines.push_back(l);
        resp_i = 1'b0;
        l = exp_lines.pop_front();
        last_line = l;
        n_cmp++;
        if (resp_o !== 1'b1 || line_o !== l) begin
            n_err++;
            $display("FAIL held_read_line got resp=%b line=%h want resp=1 line=%h",
                     resp_o, line_o, l);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [LW-1:0] l;
        logic [BW-1:0] b;
        address_i = 32'h0BAD_F00D;
        read_i = 1'b1;
        tick();
        read_i = 1'b0;
        resp_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            burst_i = {$urandom, $urandom};
            tick();
        end
        resp_i = 1'b0;
        reset = 1'b0;
        #1;
        last_line = '0;
        n_cmp++;
        if ({read_o, write_o, resp_o} !== 3'b000 || address_o !== 32'h0
            || burst_o !== '0 || line_o !== last_line) begin
            n_err++;
            $display("FAIL midreset_outs got ctl=%b addr=%h burst=%h line=%h want all 0",
                     {read_o, write_o, resp_o}, address_o, burst_o, line_o);
        end
        tick();
        tick();
        n_cmp++;
        if (resp_o !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_resp got %b want 0", resp_o);
        end
        reset = 1'b1;
        tick();
        address_i = 32'h0000_1000;
        read_i = 1'b1;
        tick();
        read_i = 1'b0;
        l = '0;
        resp_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b = {$urandom, $urandom};
            l[i*BW +: BW] = b;
            burst_i = b;
            tick();
        end
        exp_lines.push_back(l);
        resp_i = 1'b0;
        l = exp_lines.pop_front();
        last_line = l;
        n_cmp++;
        if (resp_o !== 1'b1 || line_o !== l || address_o !== 32'h0000_1000) begin
            n_err++;
            $display("FAIL postreset_read got resp=%b addr=%h line=%h want resp=1 addr=00001000 line=%h",
                     resp_o, address_o, line_o, l);
        end
        tick();
    endtask

    task automatic test_spurious();
        logic [BW-1:0] e;
        resp_i = 1'b1;
        burst_i = '1;
        tick();
        tick();
        n_cmp++;
        if ({read_o, write_o, resp_o} !== 3'b000 || line_o !== last_line) begin
            n_err++;
            $display("FAIL idle_resp got ctl=%b line=%h want ctl=000 line=%h",
                     {read_o, write_o, resp_o}, line_o, last_line);
        end
        resp_i = 1'b0;
        line_i = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        for (int i = 0; i < 4; i++) begin
            exp_beats.push_back(line_i[i*BW +: BW]);
        end
        address_i = 32'hCAFE_0123;
        write_i = 1'b1;
        tick();
        write_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            address_i = $urandom;
            resp_i = 1'b0;
            tick();
            e = exp_beats.pop_front();
            n_cmp++;
            if (address_o !== 32'hCAFE_0120 || burst_o !== e) begin
                n_err++;
                $display("FAIL addr_hold%0d got addr=%h burst=%h want addr=cafe0120 burst=%h",
                         i, address_o, burst_o, e);
            end
            resp_i = 1'b1;
            tick();
        end
        n_cmp++;
        if (resp_o !== 1'b1) begin
            n_err++;
            $display("FAIL spur_resp got %b want 1", resp_o);
        end
        tick();
        resp_i = 1'b0;
        tick();
        n_cmp++;
        if ({read_o, write_o, resp_o} !== 3'b000) begin
            n_err++;
            $display("FAIL done_resp_ignored got %b want 000", {read_o, write_o, resp_o});
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_reset_mid();
        test_spurious();
        n_cmp++;
        if (exp_beats.size() != 0 || exp_lines.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got %0d/%0d want 0/0",
                     exp_beats.size(), exp_lines.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
